seq_divider: RTL
================

# seq_divider

Sequential restoring divider: accepts an 8-bit dividend and divisor on a start pulse and produces quotient and remainder after a fixed number of iterations. It is the inverse-operation companion to the combinational add/subtract datapath in the arithmetic circuits lab, and it reuses the same trial-subtraction idea one bit per clock. It sits behind a simple start/busy/done handshake for use by lab top-levels driving switches and displays.

## Interface
- WIDTH, 8, operand/result width; iteration count equals WIDTH
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- A_in  in  WIDTH  dividend, sampled on accepting edge
- B_in  in  WIDTH  divisor, sampled on accepting edge
- Q  out  WIDTH  quotient, registered
- R  out  WIDTH  remainder, registered
- busy  out  1  high in BUSY and DONE states
- done  out  1  one-cycle result-valid strobe
- div_zero  out  1  divisor was zero for the result being presented
- overflow  out  1  result not representable (signed mode only; 0 otherwise)

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE.
- IDLE: start=1 → latch A_in, B_in; clear partial remainder (WIDTH+1 bits) and iteration counter; → BUSY. start=0 → stay.
- BUSY: each cycle shift {rem, dividend} left one bit; trial = rem − divisor (WIDTH+1-bit subtract); if trial non-negative, rem ← trial and shift in quotient bit 1, else keep rem and shift in 0. Counter increments; after WIDTH-th iteration → DONE, loading Q, R, div_zero, overflow registers on that same edge.
- DONE: done=1 for exactly one cycle; → IDLE unconditionally.
- Q, R, div_zero, overflow hold until the next result load; they are not cleared on return to IDLE.
- start while BUSY or DONE: ignored, no queuing.
- Divisor zero: algorithm runs normally; forced result Q=all ones, R=dividend, div_zero=1, same latency.
- Reset at any cycle, including mid-BUSY: → IDLE, abort operation, all outputs zero.
- Reset values: Q=0, R=0, busy=0, done=0, div_zero=0, overflow=0.

## Timing
- Edge E0 accepts start. Edges E1..EWIDTH perform iterations; EWIDTH loads results and enters DONE.
- done high during the cycle after EWIDTH (WIDTH+1 cycles after E0, 9 for default); busy high from after E0 until after E(WIDTH+1).
- Back-to-back: earliest next accept is the edge after done deasserts (throughput one result per WIDTH+2 cycles).
- No combinational path from inputs to outputs.

## Configuration
- DIVIDER_SIGNED_EN defined: operands are two's complement. On accept, magnitudes are latched; unsigned core runs; on result load Q is negated when signs of A and B differ, R takes the sign of A (truncating division). Most-negative ÷ −1 → overflow=1, Q=8'h80, R=0. Divide by zero → Q=all ones, R=A_in unchanged, div_zero=1. Latency unchanged.
- Not defined: unsigned only; overflow tied 0.

## Structure
- Shared package divider_pkg: state enumeration (IDLE, BUSY, DONE), default WIDTH constant, counter width constant ($clog2(WIDTH+1)).
- One sub-module natural: div_sub_step — combinational WIDTH+1-bit trial subtract returning difference and non-negative flag; instantiated once in the iteration datapath.

## Test plan
- Unsigned A=100, B=7, start pulse → done exactly 9 cycles after accept edge, Q=14, R=2, div_zero=0.
- A=5, B=0 → Q=8'hFF, R=5, div_zero=1, same 9-cycle latency.
- A=255, B=1 then immediately next accept A=3, B=200 → Q=255 R=0, then Q=0 R=3; start held high through BUSY/DONE produces no extra results.
- rst asserted 4 cycles into BUSY → next cycle state IDLE, all outputs 0, no done; fresh start A=9, B=3 → Q=3, R=0.
- DIVIDER_SIGNED_EN: A=−100 (8'h9C), B=7 → Q=8'hF2 (−14), R=8'hFE (−2); A=8'h80, B=8'hFF → overflow=1, Q=8'h80, R=0.
- Exhaustive sweep all 65536 operand pairs against reference model (both macro settings), checking Q, R, flags, latency.

Source files
------------

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential restoring divider:
//   - state_t    : controller states (IDLE, BUSY, DONE)
//   - DEF_WIDTH  : default operand/result width
//   - CNT_W      : iteration counter width for the default width
//   - cnt_width(): counter width for an arbitrary width
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold the values 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Start/busy/done handshake bundle for the sequential divider.
//   start            request (driven by master)
//   A_in, B_in       dividend / divisor (driven by master)
//   Q, R             quotient / remainder (driven by slave)
//   busy, done       status / one-cycle result strobe (driven by slave)
//   div_zero         divisor was zero for the presented result
//   overflow         signed result not representable
// Modports: master (requester side), slave (divider side).
// -----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, A_in, B_in,
        input  Q, R, busy, done, div_zero, overflow
    );

    modport slave (
        input  start, A_in, B_in,
        output Q, R, busy, done, div_zero, overflow
    );

endinterface

// File: rtl/div_sub_step.sv
// -----------------------------------------------------------------------------
// div_sub_step
// Combinational WIDTH+1-bit trial subtraction for one restoring-division step.
//   minuend     shifted partial remainder
//   subtrahend  zero-extended divisor
//   diff        minuend - subtrahend (WIDTH+1 bits)
//   non_neg     1 when the difference is non-negative (trial succeeds)
// -----------------------------------------------------------------------------
module div_sub_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] minuend,
    input  logic [WIDTH:0] subtrahend,
    output logic [WIDTH:0] diff,
    output logic           non_neg
);

    // While the remainder stays below the divisor the shifted value is below
    // twice the divisor, so the top bit of the difference is a valid sign.
    assign diff    = minuend - subtrahend;
    assign non_neg = ~diff[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential restoring divider, one quotient bit per clock, WIDTH iterations.
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   synchronous active-high reset (aborts any operation, clears outputs)
//   bus   seq_divider_if.slave: start/A_in/B_in in, Q/R/busy/done/div_zero/
//         overflow out (all outputs registered)
// Optional feature: define DIVIDER_SIGNED_EN for two's complement operands
// (truncating division, overflow flag for most-negative / -1). Without it the
// divider is unsigned and overflow is always 0.
// -----------------------------------------------------------------------------
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] dvd_r;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] a_orig_r;   // dividend as presented, returned as R on divide by zero
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;
    logic             ov_r;
`ifdef DIVIDER_SIGNED_EN
    logic             a_neg_r;
    logic             b_neg_r;
`endif

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic             non_neg_s;
    logic [WIDTH:0]   rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] res_q_s;
    logic [WIDTH-1:0] res_r_s;
    logic             res_dz_s;
    logic             res_ov_s;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + ONE;
    endfunction

`ifdef DIVIDER_SIGNED_EN
    // Most-negative value maps to itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return negate(v);
        end else begin
            return v;
        end
    endfunction
`endif

    // Shift next dividend bit into the partial remainder.
    assign shifted_s = (rem_r << 1) | {{WIDTH{1'b0}}, dvd_r[WIDTH-1]};

    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .minuend    (shifted_s),
        .subtrahend ({1'b0, dvs_r}),
        .diff       (diff_s),
        .non_neg    (non_neg_s)
    );

    // Restore on failed trial, keep the difference on success.
    always_comb begin
        rem_next_s = shifted_s;
        if (non_neg_s) begin
            rem_next_s = diff_s;
        end else begin
            rem_next_s = shifted_s;
        end
        quo_next_s = {dvd_r[WIDTH-2:0], non_neg_s};
    end

    // Final result formation from the last iteration's values.
    always_comb begin
        res_q_s  = quo_next_s;
        res_r_s  = rem_next_s[WIDTH-1:0];
        res_ov_s = 1'b0;
        res_dz_s = (dvs_r == {WIDTH{1'b0}});
        if (res_dz_s) begin
            res_q_s = {WIDTH{1'b1}};
            res_r_s = a_orig_r;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            if (a_neg_r ^ b_neg_r) begin
                res_q_s = negate(quo_next_s);
            end else begin
                res_q_s = quo_next_s;
            end
            if (a_neg_r) begin
                res_r_s = negate(rem_next_s[WIDTH-1:0]);
            end else begin
                res_r_s = rem_next_s[WIDTH-1:0];
            end
            // Only most-negative / -1 overflows; the core already yields MOST_NEG, R=0.
            res_ov_s = b_neg_r & (dvs_r == ONE) & (a_orig_r == MOST_NEG);
`else
            res_q_s  = quo_next_s;
            res_r_s  = rem_next_s[WIDTH-1:0];
            res_ov_s = 1'b0;
`endif
        end
    end

    // Controller FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            rem_r    <= {(WIDTH+1){1'b0}};
            dvd_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            a_orig_r <= {WIDTH{1'b0}};
            q_r      <= {WIDTH{1'b0}};
            r_r      <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
            ov_r     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_orig_r <= bus.A_in;
`ifdef DIVIDER_SIGNED_EN
                        dvd_r    <= magnitude(bus.A_in);
                        dvs_r    <= magnitude(bus.B_in);
                        a_neg_r  <= bus.A_in[WIDTH-1];
                        b_neg_r  <= bus.B_in[WIDTH-1];
`else
                        dvd_r    <= bus.A_in;
                        dvs_r    <= bus.B_in;
`endif
                        rem_r    <= {(WIDTH+1){1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= BUSY;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                BUSY: begin
                    rem_r <= rem_next_s;
                    dvd_r <= quo_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        q_r     <= res_q_s;
                        r_r     <= res_r_s;
                        dz_r    <= res_dz_s;
                        ov_r    <= res_ov_s;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= BUSY;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.Q        = q_r;
    assign bus.R        = r_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
    assign bus.overflow = ov_r;

endmodule
